// File: rtl/inner_prod_pkg.sv
// inner_prod_pkg: shared engine widths and scheduler FSM states
package inner_prod_pkg;
  localparam int IP_DATA_W = 8;
  localparam int IP_RES_W = 19;
  localparam int IP_VEC_LEN = 8;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT} st_t;
endpackage

// File: rtl/inner_prod_sched_if.sv
// inner_prod_sched_if: operand/result bus between scheduler (master) and Inner_Prod engine (slave)
interface inner_prod_sched_if;
  logic ip_valid_in;
  logic [inner_prod_pkg::IP_DATA_W-1:0] ip_A;
  logic [inner_prod_pkg::IP_DATA_W-1:0] ip_B;
  logic ip_valid_out;
  logic [inner_prod_pkg::IP_RES_W-1:0] ip_C;
  modport master (output ip_valid_in, ip_A, ip_B, input ip_valid_out, ip_C);
  modport slave (input ip_valid_in, ip_A, ip_B, output ip_valid_out, ip_C);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  // scan from the farthest offset down so the nearest set request wins
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        idx = W'((int'(ptr) + i) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/inner_prod_sched.sv
// inner_prod_sched: round-robin burst scheduler feeding one Inner_Prod engine; watchdog under INNER_PROD_SCHED_WDOG_EN
module inner_prod_sched import inner_prod_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int VEC_LEN = IP_VEC_LEN,
  parameter int WDOG_CYC = 4,
  localparam int RW = $clog2(NUM_REQ),
  localparam int EW = $clog2(VEC_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*IP_DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*IP_DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [EW-1:0]                  elem_idx,
  inner_prod_sched_if.master             ip,
  output logic                           rsp_valid,
  output logic [RW-1:0]                  rsp_id,
  output logic [IP_RES_W-1:0]            rsp_data,
  output logic                           rsp_err
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || VEC_LEN != IP_VEC_LEN || WDOG_CYC < 1) begin : g_bad_cfg
    $error("inner_prod_sched: illegal parameter set");
  end
  st_t state, state_n;
  logic [RW-1:0] rr_ptr, sel, arb_idx;
  logic arb_found, last, done, timeout;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .ptr(rr_ptr), .idx(arb_idx), .found(arb_found));
  assign last = elem_idx == EW'(VEC_LEN - 1);
`ifdef INNER_PROD_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wdog;
  assign timeout = state == WAIT && !ip.ip_valid_out && wdog == WW'(WDOG_CYC - 1);
  // count cycles spent in WAIT; restarts on every entry
  always_ff @(posedge clk or posedge rst)
    if (rst) wdog <= '0;
    else wdog <= state == WAIT ? wdog + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  assign done = state == WAIT && (ip.ip_valid_out || timeout);
  assign ip.ip_valid_in = state == STREAM;
  assign ip.ip_A = ip.ip_valid_in ? req_a[sel*IP_DATA_W +: IP_DATA_W] : '0;
  assign ip.ip_B = ip.ip_valid_in ? req_b[sel*IP_DATA_W +: IP_DATA_W] : '0;
  // next-state: grant from IDLE, stream VEC_LEN beats, wait for result or timeout
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && arb_found) ? STREAM :
              (state == STREAM && last)    ? WAIT   :
              done                         ? IDLE   : state;
  end
  // state register plus grant, element counter and response registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      sel <= '0;
      gnt <= '0;
      elem_idx <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      rsp_valid <= 1'b0;
      if (state == IDLE && arb_found) begin
        sel <= arb_idx;
        gnt <= NUM_REQ'(1) << arb_idx;
        elem_idx <= '0;
        rr_ptr <= arb_idx == RW'(NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
      end
      if (state == STREAM) begin
        elem_idx <= last ? '0 : elem_idx + 1'b1;
        if (last) gnt <= '0;
      end
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_id <= sel;
        rsp_data <= timeout ? '0 : ip.ip_C;
        rsp_err <= timeout;
      end
    end
endmodule
